// File: rtl/network_arbiter_state_writer.sv
`default_nettype none
// ============================================================================
//  Module   : network_arbiter_state_writer
//  Purpose  : Initiator side of the network arbiter state-register interface.
//             Takes trust-change requests, writes the matching state code to
//             the arbiter over valid/ready, then watches TRUSTED until the
//             arbiter reports the requested state and signals DONE.
//  Options  : NET_ARB_WRITER_TIMEOUT_EN enables the CONFIRM timeout with
//             bounded rewrites and the ERROR outcome. Without it CONFIRM
//             waits indefinitely and ERROR is tied low.
//  Revision : 1.0  initial release
// ============================================================================
module network_arbiter_state_writer #(
   parameter logic [31:0] UNTRUSTED_CODE  = 32'h0000_0001,
   parameter logic [31:0] TRUSTED_CODE    = 32'h0000_0000,
   parameter int          CONFIRM_TIMEOUT = 16,
   parameter int          MAX_RETRY       = 3
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        REQ_VALID,
   input  logic        REQ_UNTRUSTED,
   output logic        REQ_READY,
   output logic        WR_VALID,
   input  logic        WR_READY,
   output logic [31:0] WRITE_STATE_VALUE,
   input  logic        TRUSTED,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERROR,
   output logic        CUR_TRUSTED
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WRITE   = 2'd1,
      S_CONFIRM = 2'd2
   } state_t;

   state_t state;
   logic   target_untrusted;   // latched request target for the whole operation
   logic   status_match;       // arbiter status equals the requested state

`ifdef NET_ARB_WRITER_TIMEOUT_EN
   localparam int TIMER_W = $clog2(CONFIRM_TIMEOUT + 1);
   localparam int RETRY_W = $clog2(MAX_RETRY + 1);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CONFIRM_TIMEOUT - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

   logic [TIMER_W-1:0] timer;
   logic [RETRY_W-1:0] retry;
   logic               error_q;

   assign ERROR = error_q;
`else
   // Timeout parameters have no effect in this build; fold them into a
   // dead signal so they still count as referenced.
   logic unused_cfg;
   assign unused_cfg = CONFIRM_TIMEOUT[0] ^ MAX_RETRY[0];
   assign ERROR      = 1'b0;
`endif

   // Ready only when idle and out of reset, so no request is taken during reset
   assign REQ_READY    = (state == S_IDLE) && !RESET;
   assign BUSY         = (state != S_IDLE);
   assign status_match = (TRUSTED == !target_untrusted);

   // Request / write / confirm sequencer with registered outputs
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state             <= S_IDLE;
         target_untrusted  <= 1'b0;
         WR_VALID          <= 1'b0;
         WRITE_STATE_VALUE <= TRUSTED_CODE;
         DONE              <= 1'b0;
         CUR_TRUSTED       <= 1'b1;
`ifdef NET_ARB_WRITER_TIMEOUT_EN
         timer             <= '0;
         retry             <= '0;
         error_q           <= 1'b0;
`endif
      end else begin
         DONE <= 1'b0;
         case (state)
            S_IDLE: begin
               // A request equal to the current state still goes through the full write
               if (REQ_VALID) begin
                  target_untrusted  <= REQ_UNTRUSTED;
                  WRITE_STATE_VALUE <= REQ_UNTRUSTED ? UNTRUSTED_CODE : TRUSTED_CODE;
                  WR_VALID          <= 1'b1;
                  state             <= S_WRITE;
`ifdef NET_ARB_WRITER_TIMEOUT_EN
                  error_q           <= 1'b0;
                  retry             <= '0;
`endif
               end
            end
            S_WRITE: begin
               // Value and valid hold for as long as the arbiter stalls
               if (WR_READY) begin
                  WR_VALID <= 1'b0;
                  state    <= S_CONFIRM;
`ifdef NET_ARB_WRITER_TIMEOUT_EN
                  timer    <= '0;
`endif
               end
            end
            S_CONFIRM: begin
               if (status_match) begin
                  DONE        <= 1'b1;
                  CUR_TRUSTED <= !target_untrusted;
                  state       <= S_IDLE;
               end
`ifdef NET_ARB_WRITER_TIMEOUT_EN
               else if (timer >= TIMER_LAST) begin
                  // Rewrite the same value, or give up once retries are spent
                  if (retry < RETRY_MAX) begin
                     retry    <= retry + 1'b1;
                     WR_VALID <= 1'b1;
                     state    <= S_WRITE;
                  end else begin
                     error_q  <= 1'b1;
                     state    <= S_IDLE;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
`endif
            end
            default: begin
               WR_VALID <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_network_arbiter_state_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_network_arbiter_state_writer
//  Purpose  : Directed self-checking bench for network_arbiter_state_writer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_network_arbiter_state_writer;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        REQ_VALID;
   logic        REQ_UNTRUSTED;
   logic        REQ_READY;
   logic        WR_VALID;
   logic        WR_READY;
   logic [31:0] WRITE_STATE_VALUE;
   logic        TRUSTED;
   logic        BUSY;
   logic        DONE;
   logic        ERROR;
   logic        CUR_TRUSTED;

   int checks   = 0;
   int errors   = 0;
   int wr_beats = 0;
   int done_cnt = 0;
   int both_cnt = 0;
   int b0, d0, n;

   network_arbiter_state_writer dut (
      .CLK               (CLK),
      .RESET             (RESET),
      .REQ_VALID         (REQ_VALID),
      .REQ_UNTRUSTED     (REQ_UNTRUSTED),
      .REQ_READY         (REQ_READY),
      .WR_VALID          (WR_VALID),
      .WR_READY          (WR_READY),
      .WRITE_STATE_VALUE (WRITE_STATE_VALUE),
      .TRUSTED           (TRUSTED),
      .BUSY              (BUSY),
      .DONE              (DONE),
      .ERROR             (ERROR),
      .CUR_TRUSTED       (CUR_TRUSTED)
   );

   always #5 CLK = ~CLK;

   // Count write handshakes, DONE pulses and any DONE/ERROR overlap
   always @(posedge CLK) begin
      if (!RESET) begin
         if (WR_VALID && WR_READY) wr_beats <= wr_beats + 1;
         if (DONE)                 done_cnt <= done_cnt + 1;
         if (DONE && ERROR)        both_cnt <= both_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int cycles = 1);
      repeat (cycles) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic wait_done(input string tag);
      int k = 0;
      while (!DONE && k < 20) begin
         step();
         k++;
      end
      check(tag, DONE, 1);
   endtask

   initial begin
      RESET = 1'b1; REQ_VALID = 1'b0; REQ_UNTRUSTED = 1'b0;
      WR_READY = 1'b0; TRUSTED = 1'b1;

      // ---- reset state ----
      step(3);
      check("rst_req_ready", REQ_READY, 0);
      check("rst_wr_valid",  WR_VALID, 0);
      check("rst_busy",      BUSY, 0);
      check("rst_done",      DONE, 0);
      check("rst_error",     ERROR, 0);
      check("rst_cur",       CUR_TRUSTED, 1);
      check("rst_value",     WRITE_STATE_VALUE, 32'h0);
      RESET = 1'b0; #1;
      check("rel_req_ready", REQ_READY, 1);

      // ---- untrusted request, best-case timing ----
      REQ_VALID = 1'b1; REQ_UNTRUSTED = 1'b1; WR_READY = 1'b1;
      step();                                  // accept edge N
      REQ_VALID = 1'b0;
      check("u_wr_valid",  WR_VALID, 1);
      check("u_value",     WRITE_STATE_VALUE, 32'h1);
      check("u_busy",      BUSY, 1);
      check("u_req_ready", REQ_READY, 0);
      step();                                  // handshake N+1
      check("u_wr_low",    WR_VALID, 0);
      check("u_no_done",   DONE, 0);
      TRUSTED = 1'b0;
      step();                                  // match sampled N+2
      check("u_done",      DONE, 1);
      check("u_ready_n3",  REQ_READY, 1);
      check("u_cur",       CUR_TRUSTED, 0);
      step();
      check("u_done_pulse", DONE, 0);
      check("u_beats",     wr_beats, 1);

      // ---- trusted request with 5-cycle WR_READY stall ----
      REQ_VALID = 1'b1; REQ_UNTRUSTED = 1'b0; WR_READY = 1'b0;
      step();
      REQ_VALID = 1'b0;
      check("s_wr_valid0", WR_VALID, 1);
      check("s_value0",    WRITE_STATE_VALUE, 32'h0);
      for (int i = 0; i < 5; i++) begin
         step();
         check("s_wr_valid", WR_VALID, 1);
         check("s_value",    WRITE_STATE_VALUE, 32'h0);
         check("s_no_done",  DONE, 0);
      end
      WR_READY = 1'b1;
      step();
      check("s_wr_low", WR_VALID, 0);
      TRUSTED = 1'b1;
      step();
      check("s_done",  DONE, 1);
      check("s_cur",   CUR_TRUSTED, 1);
      check("s_beats", wr_beats, 2);

      // ---- same-state request, REQ_VALID held while busy ----
      step();
      b0 = wr_beats; d0 = done_cnt;
      REQ_VALID = 1'b1; REQ_UNTRUSTED = 1'b0; WR_READY = 1'b0;
      step();                                  // accept
      REQ_UNTRUSTED = 1'b1;                    // busy-time request must be ignored
      step(2);
      check("b_value_held", WRITE_STATE_VALUE, 32'h0);
      WR_READY = 1'b1;
      step();                                  // handshake, now CONFIRM
      REQ_VALID = 1'b0;
      step();
      check("b_done", DONE, 1);
      step(3);
      check("b_one_write", wr_beats - b0, 1);
      check("b_one_done",  done_cnt - d0, 1);
      check("b_cur",       CUR_TRUSTED, 1);
      check("b_idle",      BUSY, 0);

      // ---- reset during CONFIRM ----
      REQ_VALID = 1'b1; REQ_UNTRUSTED = 1'b1;
      step();
      REQ_VALID = 1'b0;
      step();
      TRUSTED = 1'b0;
      wait_done("r_prep_done");
      step();
      check("r_prep_cur", CUR_TRUSTED, 0);
      d0 = done_cnt;
      REQ_VALID = 1'b1; REQ_UNTRUSTED = 1'b0;  // TRUSTED stays 0: never matches
      step();
      REQ_VALID = 1'b0;
      step(3);
      check("r_busy_confirm", BUSY, 1);
      RESET = 1'b1;
      step();
      check("r_busy",      BUSY, 0);
      check("r_wr_valid",  WR_VALID, 0);
      check("r_cur",       CUR_TRUSTED, 1);
      check("r_done",      DONE, 0);
      check("r_req_ready", REQ_READY, 0);
      RESET = 1'b0; TRUSTED = 1'b1;
      step();
      check("r_no_done", done_cnt - d0, 0);
      check("r_ready",   REQ_READY, 1);

`ifdef NET_ARB_WRITER_TIMEOUT_EN
      // ---- timeout: TRUSTED never matches, 1 + MAX_RETRY writes then ERROR ----
      b0 = wr_beats; d0 = done_cnt;
      REQ_VALID = 1'b1; REQ_UNTRUSTED = 1'b1; WR_READY = 1'b1;
      step();
      REQ_VALID = 1'b0;
      n = 0;
      while (!ERROR && n < 200) begin
         step();
         n++;
      end
      check("t_cycles", n, 68);
      check("t_error",  ERROR, 1);
      check("t_writes", wr_beats - b0, 4);
      check("t_no_done", done_cnt - d0, 0);
      check("t_cur",    CUR_TRUSTED, 1);
      check("t_idle",   BUSY, 0);
      REQ_VALID = 1'b1; REQ_UNTRUSTED = 1'b0;
      step();
      REQ_VALID = 1'b0;
      check("t_err_clear", ERROR, 0);
      step();
      wait_done("t_recover_done");
`else
      // ---- no timeout: CONFIRM waits indefinitely, ERROR stays low ----
      d0 = done_cnt;
      REQ_VALID = 1'b1; REQ_UNTRUSTED = 1'b1; WR_READY = 1'b1;
      step();
      REQ_VALID = 1'b0;
      step(40);
      check("w_still_busy", BUSY, 1);
      check("w_no_error",   ERROR, 0);
      check("w_no_done",    done_cnt - d0, 0);
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      step();
      check("w_reset_idle", BUSY, 0);
`endif

      check("never_done_and_error", both_cnt, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
